// File: rtl/frame_run_ctrl_pkg.sv
// Shared state encoding for the frame run controller and any status/debug logic.
// The encoding is visible on the state output, so the values are fixed.
package frame_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_WAIT  = 2'd3
    } frame_state_e;

    // Minimum counter width able to hold values 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_run_ctrl_raster.sv
// Raster position counter: walks x across a line, then y down the frame.
// The last output flags the final pixel position of the frame.
module raster_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = 10,
    parameter int YW    = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic          x_at_end;
    logic          y_at_end;

    assign x_at_end = (x_reg == X_LAST);
    assign y_at_end = (y_reg == Y_LAST);

    // clr wins over en so an abort on the accept cycle discards that pixel too.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (clr) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (en) begin
            if (x_at_end) begin
                x_reg <= '0;
                y_reg <= y_at_end ? '0 : y_reg + YW'(1);
            end else begin
                x_reg <= x_reg + XW'(1);
            end
        end
    end

    assign x    = x_reg;
    assign y    = y_reg;
    assign last = x_at_end & y_at_end;

endmodule

// File: rtl/frame_run_ctrl.sv
// Frame run controller: gates the pixel stream, tracks raster position and
// sequences single-shot / continuous frames with pause, abort and inter-frame gap.
module frame_run_ctrl
    import frame_ctrl_pkg::*;
#(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int FCW       = 8,
    parameter int FRAME_GAP = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stop,
    input  logic           abort,
    input  logic           mode,
    input  logic           pix_valid,
    output logic           pix_ready,
    output logic [XW-1:0]  x,
    output logic [YW-1:0]  y,
    output logic           sof,
    output logic           eol,
    output logic           eof,
    output logic           frame_done,
    output logic [FCW-1:0] frame_cnt,
    output logic [1:0]     state
);

    localparam int              GW       = cnt_width(FRAME_GAP);
    localparam logic [GW-1:0]   GAP_LAST = GW'(FRAME_GAP - 1);
    localparam logic [XW-1:0]   X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]   Y_LAST   = YW'(IMG_H - 1);

    frame_state_e   state_reg, state_next;
    logic [GW-1:0]  gap_reg, gap_next;
    logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
    logic           frame_done_reg, frame_done_next;

    logic accept;
    logic last_pos;
    logic last_accept;
    logic raster_clr;

    assign pix_ready   = (state_reg == ST_RUN);
    assign accept      = pix_valid & pix_ready;
    assign last_accept = accept & last_pos;
    assign raster_clr  = abort | (state_reg == ST_INIT);

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clr   (raster_clr),
        .en    (accept),
        .x     (x),
        .y     (y),
        .last  (last_pos)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_INIT;
            gap_reg        <= '0;
            frame_cnt_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            gap_reg        <= gap_next;
            frame_cnt_reg  <= frame_cnt_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Priority: abort > last-pixel completion > stop > start / gap expiry.
    always_comb begin
        state_next      = state_reg;
        gap_next        = gap_reg;
        frame_cnt_next  = frame_cnt_reg;
        frame_done_next = 1'b0;

        if (abort) begin
            state_next = ST_INIT;
            gap_next   = '0;
        end else begin
            unique case (state_reg)
                ST_INIT: begin
                    if (start) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_accept) begin
                        frame_cnt_next  = frame_cnt_reg + FCW'(1);
                        frame_done_next = 1'b1;
                        gap_next        = '0;
                        state_next      = mode ? ST_INIT : ST_WAIT;
                    end else if (stop) begin
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (!stop) begin
                        state_next = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    gap_next = gap_reg + GW'(1);
                    if (stop) begin
                        state_next = ST_INIT;
                    end else if (gap_reg == GAP_LAST) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_INIT;
                end
            endcase
        end
    end

    assign sof        = pix_ready & (x == '0) & (y == '0);
    assign eol        = pix_ready & (x == X_LAST);
    assign eof        = eol & (y == Y_LAST);
    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_frame_run_ctrl.sv
// Directed bench for frame_run_ctrl with a 4x3 frame, 2-cycle gap and 2-bit frame counter.
module tb_frame_run_ctrl;

    localparam int IMG_W     = 4;
    localparam int IMG_H     = 3;
    localparam int XW        = 2;
    localparam int YW        = 2;
    localparam int FCW       = 2;
    localparam int FRAME_GAP = 2;

    localparam int S_INIT  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_WAIT  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           abort = 1'b0;
    logic           mode = 1'b0;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           sof;
    logic           eol;
    logic           eof;
    logic           frame_done;
    logic [FCW-1:0] frame_cnt;
    logic [1:0]     state;

    int total = 0;
    int bad   = 0;

    frame_run_ctrl #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .XW        (XW),
        .YW        (YW),
        .FCW       (FCW),
        .FRAME_GAP (FRAME_GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .abort      (abort),
        .mode       (mode),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .x          (x),
        .y          (y),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk({tag, ".x"}, 32'(x), 32'(ex));
        chk({tag, ".y"}, 32'(y), 32'(ey));
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst.state", 32'(state), 32'(S_INIT));
        chk_pos("rst", 0, 0);
        chk("rst.ready", 32'(pix_ready), 32'(0));
        chk("rst.done", 32'(frame_done), 32'(0));
        chk("rst.cnt", 32'(frame_cnt), 32'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("init.state", 32'(state), 32'(S_INIT));

        // Single-shot frame
        mode = 1'b1; pix_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ss.state", 32'(state), 32'(S_RUN));
        for (int i = 0; i < 12; i++) begin
            chk_pos($sformatf("ss.p%0d", i), i % 4, i / 4);
            chk($sformatf("ss.sof%0d", i), 32'(sof), 32'(i == 0));
            chk($sformatf("ss.eol%0d", i), 32'(eol), 32'(i % 4 == 3));
            chk($sformatf("ss.eof%0d", i), 32'(eof), 32'(i == 11));
            chk($sformatf("ss.done%0d", i), 32'(frame_done), 32'(0));
            tick();
        end
        chk("ss.done", 32'(frame_done), 32'(1));
        chk("ss.end_state", 32'(state), 32'(S_INIT));
        chk("ss.cnt", 32'(frame_cnt), 32'(1));
        chk_pos("ss.end", 0, 0);
        tick();
        chk("ss.done_pulse", 32'(frame_done), 32'(0));
        chk("ss.idle", 32'(state), 32'(S_INIT));

        // Continuous: restart the counter from zero, run 4 frames, last one single-shot
        reset = 1'b0;
        #1;
        reset = 1'b1;
        chk("ct.cnt0", 32'(frame_cnt), 32'(0));
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 4; f++) begin
            chk($sformatf("ct.f%0d.state", f), 32'(state), 32'(S_RUN));
            chk_pos($sformatf("ct.f%0d.start", f), 0, 0);
            if (f == 3) mode = 1'b1;
            for (int i = 0; i < 12; i++) tick();
            chk($sformatf("ct.f%0d.done", f), 32'(frame_done), 32'(1));
            chk($sformatf("ct.f%0d.cnt", f), 32'(frame_cnt), 32'((f + 1) % 4));
            if (f < 3) begin
                chk($sformatf("ct.f%0d.wait1", f), 32'(state), 32'(S_WAIT));
                chk($sformatf("ct.f%0d.rdy1", f), 32'(pix_ready), 32'(0));
                tick();
                chk($sformatf("ct.f%0d.wait2", f), 32'(state), 32'(S_WAIT));
                chk($sformatf("ct.f%0d.rdy2", f), 32'(pix_ready), 32'(0));
                chk($sformatf("ct.f%0d.done_off", f), 32'(frame_done), 32'(0));
                tick();
            end else begin
                chk("ct.single_end", 32'(state), 32'(S_INIT));
            end
        end

        // Pause at x=2,y=1 for 5 cycles
        tick();
        mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk_pos("pz.pre", 2, 1);
        pix_valid = 1'b0; stop = 1'b1;
        tick();
        pix_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("pz.state%0d", i), 32'(state), 32'(S_PAUSE));
            chk($sformatf("pz.rdy%0d", i), 32'(pix_ready), 32'(0));
            chk_pos($sformatf("pz.hold%0d", i), 2, 1);
            start = (i == 2);
            if (i == 4) stop = 1'b0;
            tick();
        end
        start = 1'b0;
        chk("pz.resume", 32'(state), 32'(S_RUN));
        chk_pos("pz.resume", 2, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("pz.eof", 32'(eof), 32'(1));
        tick();
        chk("pz.done", 32'(frame_done), 32'(1));
        chk("pz.cnt", 32'(frame_cnt), 32'(1));
        chk("pz.end", 32'(state), 32'(S_INIT));

        // Abort with last pixel pending
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        chk_pos("ab.pre", 3, 2);
        chk("ab.eof", 32'(eof), 32'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab.state", 32'(state), 32'(S_INIT));
        chk_pos("ab.post", 0, 0);
        chk("ab.done", 32'(frame_done), 32'(0));
        chk("ab.cnt", 32'(frame_cnt), 32'(1));
        tick();
        chk("ab.done_late", 32'(frame_done), 32'(0));

        // Last-pixel accept colliding with stop in continuous mode
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        stop = 1'b1;
        tick();
        chk("co.done", 32'(frame_done), 32'(1));
        chk("co.state", 32'(state), 32'(S_WAIT));
        chk("co.cnt", 32'(frame_cnt), 32'(2));
        tick();
        chk("co.init", 32'(state), 32'(S_INIT));
        stop = 1'b0;

        // Async reset mid-RUN, between edges
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk_pos("ar.pre", 2, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.state", 32'(state), 32'(S_INIT));
        chk_pos("ar.post", 0, 0);
        chk("ar.rdy", 32'(pix_ready), 32'(0));
        chk("ar.cnt", 32'(frame_cnt), 32'(0));
        tick();
        chk("ar.done", 32'(frame_done), 32'(0));
        reset = 1'b1;
        tick();
        chk("ar.hold", 32'(state), 32'(S_INIT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
